// File: rtl/multiport_register_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared constants and helpers for the multiport register file
//                and its pending-write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int BYTE_LANES         = DEFAULT_DATA_WIDTH / 8;

    // Merge one byte lane: the new byte replaces the old one only when its
    // enable bit is set. Applied lane by lane so any multiple-of-8 width works.
    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       mask
    );
        return mask ? new_byte : old_byte;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multiport_register_file_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : rf_scoreboard
//  Description : Per-register pending bits. Decode sets a bit on reserve,
//                writeback clears it; a same-cycle reserve wins over the clear.
//                Provides the WAW hazard flag and per-port pending lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  wire logic                             clk,
    input  wire logic                             rst,
    input  wire logic                             set_en_i,
    input  wire logic [ADDR_WIDTH-1:0]            set_addr_i,
    input  wire logic                             clr_en_i,
    input  wire logic [ADDR_WIDTH-1:0]            clr_addr_i,
    input  wire logic [READ_PORTS*ADDR_WIDTH-1:0] lookup_addr_i,
    output logic      [READ_PORTS-1:0]            pending_o,
    output logic                                  hazard_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;
    logic             w_set_valid;
    logic             w_clr_valid;

    // Register 0 (when hard-wired) never takes part in the scoreboard.
    assign w_set_valid = set_en_i && !((ZERO_REG != 0) && (set_addr_i == '0));
    assign w_clr_valid = clr_en_i && !((ZERO_REG != 0) && (clr_addr_i == '0));

    // Next pending vector: clear first, then set, so a new producer wins.
    always_comb begin
        pending_d = pending_q;
        if (w_clr_valid) begin
            pending_d[clr_addr_i] = 1'b0;
        end
        if (w_set_valid) begin
            pending_d[set_addr_i] = 1'b1;
        end
    end

    // Pending state register; reset discards every in-flight reservation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign hazard_o = w_set_valid & pending_q[set_addr_i];

    generate
        for (genvar p = 0; p < READ_PORTS; p++) begin : g_lookup
            logic [ADDR_WIDTH-1:0] w_addr;
            logic                  w_clear_hit;

            assign w_addr      = lookup_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
            // A same-cycle writeback already delivers the data, so the
            // register is no longer outstanding from the reader's viewpoint.
            assign w_clear_hit = (BYPASS != 0) && w_clr_valid && (clr_addr_i == w_addr);
            assign pending_o[p] = pending_q[w_addr] & ~w_clear_hit;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/multiport_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : multiport_register_file
//  Description : Parametrised register file with N combinational read ports,
//                byte-enabled writeback, optional write-to-read bypass,
//                optional hard-wired zero register and a pending scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module multiport_register_file
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  wire logic                             clk,
    input  wire logic                             rst,
    input  wire logic [READ_PORTS*ADDR_WIDTH-1:0] readAddress,
    output logic      [READ_PORTS*DATA_WIDTH-1:0] readData,
    output logic      [READ_PORTS-1:0]            readPending,
    input  wire logic                             writeEnable,
    input  wire logic [ADDR_WIDTH-1:0]            writeAddress,
    input  wire logic [DATA_WIDTH-1:0]            writeData,
    input  wire logic [DATA_WIDTH/8-1:0]          writeByteEnable,
    input  wire logic                             reserveEnable,
    input  wire logic [ADDR_WIDTH-1:0]            reserveAddress,
    output logic                                  reserveHazard
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic                  w_write_valid;
    logic [DATA_WIDTH-1:0] w_write_merged;

    assign w_write_valid = writeEnable && !((ZERO_REG != 0) && (writeAddress == '0));

    // The merged word serves both the storage update and the bypass path,
    // since a bypass only fires when the read address equals writeAddress.
    generate
        for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
            assign w_write_merged[b*8 +: 8] = byte_merge(regs_q[writeAddress][b*8 +: 8],
                                                         writeData[b*8 +: 8],
                                                         writeByteEnable[b]);
        end
    endgenerate

    // Storage array: cleared on reset, otherwise updated by the writeback port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= '0;
            end
        end else if (w_write_valid) begin
            regs_q[writeAddress] <= w_write_merged;
        end
    end

    generate
        for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
            logic [ADDR_WIDTH-1:0] w_addr;
            logic                  w_bypass_hit;
            logic                  w_zero_hit;

            assign w_addr       = readAddress[p*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_bypass_hit = (BYPASS != 0) && w_write_valid && (writeAddress == w_addr);
            assign w_zero_hit   = (ZERO_REG != 0) && (w_addr == '0);

            assign readData[p*DATA_WIDTH +: DATA_WIDTH] =
                w_bypass_hit ? w_write_merged :
                w_zero_hit   ? '0             :
                               regs_q[w_addr];
        end
    endgenerate

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .READ_PORTS (READ_PORTS),
        .ZERO_REG   (ZERO_REG),
        .BYPASS     (BYPASS)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .set_en_i      (reserveEnable),
        .set_addr_i    (reserveAddress),
        .clr_en_i      (writeEnable),
        .clr_addr_i    (writeAddress),
        .lookup_addr_i (readAddress),
        .pending_o     (readPending),
        .hazard_o      (reserveHazard)
    );

endmodule
`default_nettype wire

// File: tb/tb_multiport_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiport_register_file
//  Description : Self-checking bench for multiport_register_file. Drives one
//                bypassing and one non-bypassing instance with the same
//                stimulus and compares both against an array-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multiport_register_file;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NP    = 2;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP*AW-1:0] readAddress;
    logic [NP*DW-1:0] rd_b, rd_n;
    logic [NP-1:0]    rp_b, rp_n;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [3:0]    be;
    logic          re;
    logic [AW-1:0] ra;
    logic          hz_b, hz_n;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference state
    logic [DW-1:0] mem  [DEPTH];
    bit            pend [DEPTH];

    // Values seen at the last sample point, for directed constant checks
    logic [NP*DW-1:0] obs_rd_b, obs_rd_n;
    logic [NP-1:0]    obs_rp_b;
    logic             obs_hz_b;

    always #5 clk = ~clk;

    multiport_register_file #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .READ_PORTS (NP), .ZERO_REG (1), .BYPASS (1)
    ) dut (
        .clk (clk), .rst (rst), .readAddress (readAddress), .readData (rd_b),
        .readPending (rp_b), .writeEnable (we), .writeAddress (wa), .writeData (wd),
        .writeByteEnable (be), .reserveEnable (re), .reserveAddress (ra),
        .reserveHazard (hz_b)
    );

    multiport_register_file #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .READ_PORTS (NP), .ZERO_REG (1), .BYPASS (0)
    ) dut_nb (
        .clk (clk), .rst (rst), .readAddress (readAddress), .readData (rd_n),
        .readPending (rp_n), .writeEnable (we), .writeAddress (wa), .writeData (wd),
        .writeByteEnable (be), .reserveEnable (re), .reserveAddress (ra),
        .reserveHazard (hz_n)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] mask);
        logic [31:0] m = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) m = m | (32'hFF << (8 * i));
        end
        return (old_v & ~m) | (new_v & m);
    endfunction

    function automatic bit write_hits(input logic [4:0] a);
        return (we == 1'b1) && (wa != 0) && (wa == a);
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        if (byp && write_hits(a)) return merge(mem[a], wd, be);
        return mem[a];
    endfunction

    function automatic logic exp_pend(input logic [4:0] a, input bit byp);
        if (byp && write_hits(a)) return 1'b0;
        return pend[a];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]  = '0;
            pend[i] = 1'b0;
        end
    endfunction

    // One clock cycle: apply inputs, check at mid-cycle, clock, update model.
    task automatic step(input logic r, input logic w, input logic [4:0] wa_v,
                        input logic [31:0] wd_v, input logic [3:0] be_v,
                        input logic rv, input logic [4:0] ra_v,
                        input logic [4:0] a0, input logic [4:0] a1);
        logic [4:0] pa [NP];
        rst = r; we = w; wa = wa_v; wd = wd_v; be = be_v;
        re = rv; ra = ra_v; readAddress = {a1, a0};
        pa[0] = a0; pa[1] = a1;
        #4;
        for (int p = 0; p < NP; p++) begin
            check($sformatf("rdata_byp[%0d]@%0d", p, pa[p]), rd_b[p*DW +: DW], exp_data(pa[p], 1'b1));
            check($sformatf("rpend_byp[%0d]@%0d", p, pa[p]), rp_b[p], exp_pend(pa[p], 1'b1));
            check($sformatf("rdata_nb[%0d]@%0d", p, pa[p]), rd_n[p*DW +: DW], exp_data(pa[p], 1'b0));
            check($sformatf("rpend_nb[%0d]@%0d", p, pa[p]), rp_n[p], exp_pend(pa[p], 1'b0));
        end
        check("hazard_byp", hz_b, re && (ra != 0) && pend[ra]);
        check("hazard_nb",  hz_n, re && (ra != 0) && pend[ra]);
        obs_rd_b = rd_b; obs_rd_n = rd_n; obs_rp_b = rp_b; obs_hz_b = hz_b;
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else begin
            if (w && wa_v != 0) begin
                mem[wa_v]  = merge(mem[wa_v], wd_v, be_v);
                pend[wa_v] = 1'b0;
            end
            if (rv && ra_v != 0) pend[ra_v] = 1'b1;
        end
        #1;
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; wa = '0; wd = '0; be = '0; re = 1'b0; ra = '0;
        readAddress = '0;
        @(posedge clk);
        @(posedge clk);
        model_reset();
        #1;

        // Reset sweep: everything reads zero and not pending
        for (int a = 0; a < DEPTH; a += 2) begin
            step(1, 0, 0, 0, 0, 0, 0, 5'(a), 5'(a + 1));
        end

        // Write and read, with and without bypass
        step(1, 1, 5, 32'hDEADBEEF, 4'hF, 0, 0, 5, 5);
        check("wr5_same_byp", obs_rd_b[31:0], 32'hDEADBEEF);
        check("wr5_same_nb",  obs_rd_n[31:0], 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 5, 0);
        check("wr5_next", obs_rd_b[31:0], 32'hDEADBEEF);

        // Bypass with partial byte enables on two ports
        step(1, 1, 7, 32'h11223344, 4'hF, 0, 0, 1, 2);
        step(1, 1, 7, 32'hAABBCCDD, 4'b0101, 0, 0, 7, 7);
        check("byp7_p0", obs_rd_b[31:0],  32'h11BB33DD);
        check("byp7_p1", obs_rd_b[63:32], 32'h11BB33DD);
        step(1, 0, 0, 0, 0, 0, 0, 7, 7);
        check("reg7_next", obs_rd_b[31:0], 32'h11BB33DD);

        // Scoreboard lifecycle on reg 9
        step(1, 0, 0, 0, 0, 1, 9, 9, 9);
        step(1, 0, 0, 0, 0, 1, 9, 9, 9);
        check("pend9_set", obs_rp_b[0], 1'b1);
        check("hazard9",   obs_hz_b,    1'b1);
        step(1, 1, 9, 32'h00000009, 4'hF, 0, 0, 9, 9);
        check("pend9_wr_byp", obs_rp_b[0], 1'b0);
        step(1, 0, 0, 0, 0, 0, 0, 9, 9);
        check("pend9_after", obs_rp_b[0], 1'b0);

        // Reserve and write reg 12 together: new producer keeps it pending
        step(1, 1, 12, 32'h12345678, 4'hF, 1, 12, 1, 2);
        step(1, 0, 0, 0, 0, 0, 0, 12, 12);
        check("reg12_data", obs_rd_b[31:0], 32'h12345678);
        check("reg12_pend", obs_rp_b[0], 1'b1);

        // Zero register ignores writes and reserves
        step(1, 1, 0, 32'hFFFFFFFF, 4'hF, 1, 0, 0, 0);
        check("zero_data", obs_rd_b[31:0], 32'h0);
        step(1, 0, 0, 0, 0, 1, 0, 0, 0);
        check("zero_pend",   obs_rp_b[0], 1'b0);
        check("zero_hazard", obs_hz_b,    1'b0);

        // Reset with reg 3 pending, simultaneous write/reserve are lost
        step(1, 1, 3, 32'hCAFE0003, 4'hF, 1, 3, 3, 3);
        step(1, 0, 0, 0, 0, 0, 0, 3, 3);
        check("reg3_pend_pre", obs_rp_b[0], 1'b1);
        step(0, 1, 3, 32'h33333333, 4'hF, 1, 5, 3, 5);
        step(1, 0, 0, 0, 0, 0, 0, 3, 5);
        check("reg3_rst_data", obs_rd_b[31:0], 32'h0);
        check("reg3_rst_pend", obs_rp_b[0],    1'b0);
        check("reg5_rst_pend", obs_rp_b[1],    1'b0);

        // Random traffic, addresses biased to a small set to force collisions
        for (int n = 0; n < 600; n++) begin
            logic [4:0] w_a, r_a, p0, p1;
            w_a = 5'($urandom_range(0, 11));
            r_a = 5'($urandom_range(0, 11));
            p0  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 11));
            p1  = ($urandom_range(0, 3) == 0) ? w_a : 5'($urandom_range(0, 11));
            step(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)), w_a, 32'($urandom),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), r_a, p0, p1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multiport_register_file.md
# multiport_register_file

Parametrised general-purpose register file for the RISC core, successor to the fixed 32×32, two-read/one-write file. Adds configurable width, depth and read-port count, byte-enabled writes, write-to-read bypass and a per-register pending scoreboard. It sits between decode (read and reserve) and writeback (write and clear), so the decoder can detect RAW/WAW hazards without external tracking.

## Interface
- DATA_WIDTH, 32, register width in bits; multiple of 8.
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH.
- READ_PORTS, 2, number of independent combinational read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads as zero and ignores writes and reserves.
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- readAddress  in  READ_PORTS*ADDR_WIDTH  packed read addresses; port i occupies slice i.
- readData  out  READ_PORTS*DATA_WIDTH  packed read data.
- readPending  out  READ_PORTS  scoreboard bit for each read port's address.
- writeEnable  in  1  writeback strobe.
- writeAddress  in  ADDR_WIDTH  writeback destination.
- writeData  in  DATA_WIDTH  writeback value.
- writeByteEnable  in  DATA_WIDTH/8  per-byte write mask.
- reserveEnable  in  1  decode marks a destination as pending.
- reserveAddress  in  ADDR_WIDTH  register to reserve.
- reserveHazard  out  1  reserveEnable with the target already pending (WAW).

## Operation
- Reset: on a rising edge with rst=0, every register is cleared to 0 and every pending bit is cleared. All outputs are 0 from the following cycle, given in-range addresses and no write or reserve.
- Write: on a rising edge with writeEnable=1, each byte lane with writeByteEnable=1 is updated. Other lanes keep their old value.
- Pending clear: the same write edge clears pending[writeAddress].
- Zero register: with ZERO_REG=1, register 0 always reads 0 and never reports pending. Writes and reserves to it are dropped.
- Reserve: on a rising edge with reserveEnable=1, pending[reserveAddress] is set.
- Reserve/write collision: reserve and write to the same address in one cycle leave pending set, because the new producer wins.
- Redundant operations: reserving an already-pending register keeps it set and raises reserveHazard in that cycle. A write to a non-pending register is legal and has no side effect on the scoreboard.
- Read data: readData[i] = register[readAddress[i]].
- Bypass data: with BYPASS=1, writeEnable=1, writeAddress equal to readAddress[i] and that address valid (non-zero under ZERO_REG), readData[i] is the merged value: new bytes where enabled, old bytes elsewhere.
- readPending[i] = pending[readAddress[i]]. With BYPASS=1 it is forced to 0 when a same-cycle write targets that address.
- reserveHazard is combinational: reserveEnable & pending[reserveAddress] & valid address.
- Port independence: all read ports are independent. Identical addresses on several ports are legal.

## Timing
- Read latency 0: data and pending are combinational from addresses and current state.
- Write visibility: the next cycle, or the same cycle through bypass when BYPASS=1. With BYPASS=0, a same-cycle read returns the old value.
- Scoreboard latency: reserve and clear take effect in the cycle after the edge.
- Reset priority: reset takes priority over any simultaneous write or reserve. Reset asserted mid-sequence discards in-flight pending state.
- Simulation side effects: no initial-file loading and no $monitor in RTL; initial state comes from reset only.

## Structure
- Package rf_pkg:
  - default DATA_WIDTH/ADDR_WIDTH constants;
  - function byte_merge(old, new, mask);
  - localparam BYTE_LANES = DATA_WIDTH/8.
- Sub-module rf_scoreboard (DEPTH-bit pending vector with set/clear/priority logic, reserveHazard, per-port pending lookup). The top module instantiates it alongside the storage array and read muxes.

## Test plan
- Reset: rst=0 for one edge, then read all addresses -> readData=0 and readPending=0 everywhere.
- Write and read: write 0xDEADBEEF to reg 5 with byte enables 0xF; the next cycle read 5 on port 0 -> 0xDEADBEEF. Repeat with BYPASS=0 and a same-cycle read -> old value 0.
- Bypass with partial byte enables: reg 7 holds 0x11223344; write 0xAABBCCDD to reg 7 with enables 0b0101 while reading 7 on ports 0 and 1 -> both ports read 0x11BB33DD in the same cycle. The next cycle reg 7 holds 0x11BB33DD.
- Scoreboard lifecycle: reserve reg 9 -> readPending=1 on the next cycle. Reserve 9 again -> reserveHazard=1. Write 9 -> readPending=0 in the same cycle (bypass) and stays 0 after.
- Reserve/write collision: reserve and write reg 12 in one cycle -> reg 12 takes the new data and pending remains 1.
- Zero register: write 0xFFFFFFFF and reserve to reg 0 -> reads 0, readPending=0, reserveHazard=0. Assert rst=0 while reg 3 is pending -> pending cleared and reg 3 reads 0.
